// File: rtl/conv_line_buffer_pkg.sv
// conv_line_buffer_pkg
//   Shared definitions for the 3x3 convolution datapath: default image
//   geometry, pixel width and the tap bundle passed from the line buffer to
//   the three row filters (and on to conv2D_out).
//   No ports; imported with "import conv_line_buffer_pkg::*;".
package conv_line_buffer_pkg;

    localparam int CONV_IMG_W = 6;
    localparam int CONV_IMG_H = 6;
    localparam int CONV_PIX_W = 4;

    // One vertical column of the window: tap0 = row r-2, tap1 = row r-1,
    // tap2 = row r. win_valid marks a tap set that closes a full 3x3 window.
    typedef struct packed {
        logic [CONV_PIX_W-1:0] tap0;
        logic [CONV_PIX_W-1:0] tap1;
        logic [CONV_PIX_W-1:0] tap2;
        logic                  win_valid;
    } conv_tap_t;

endpackage

// File: rtl/conv_line_buffer_ram.sv
// conv_lb_ram
//   One image row of pixel storage: DEPTH x WIDTH, one write port and one
//   combinational read port. The read returns the pre-write value when the
//   same address is written on the same edge, which the line buffer relies
//   on to shift a column up by one row.
//   Ports:
//     CLK      in   1      clock, rising edge
//     we_i     in   1      write enable
//     waddr_i  in   AW     write address
//     wdata_i  in   WIDTH  write data
//     raddr_i  in   AW     read address
//     rdata_o  out  WIDTH  read data (combinational)
module conv_lb_ram #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are deliberately not reset; the line buffer masks rows that
    // have not been written in the current frame.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer
//   Raster-to-window feeder for the 3x3 conv datapath. Takes one pixel per
//   accepted beat in row-major order, keeps the two previous rows in two
//   circular line buffers and, one cycle later, presents the vertical taps
//   (r-2,c), (r-1,c), (r,c) together with the filter enable strobe, the
//   window-valid flag, the window top-left position and an end-of-frame flag.
//   Ports:
//     CLK          in   1      clock, rising edge
//     reset        in   1      asynchronous, active-low
//     pix_valid    in   1      pixel present on pix_i
//     pix_ready    out  1      block can accept (= ~hold_i)
//     pix_i        in   PIX_W  pixel value
//     sof_i        in   1      beat is pixel (0,0); only looked at on accept
//     hold_i       in   1      downstream stall, freezes the block
//     tap0_o       out  PIX_W  pixel (r-2,c), top-row filter
//     tap1_o       out  PIX_W  pixel (r-1,c), middle-row filter
//     tap2_o       out  PIX_W  pixel (r,c), bottom-row filter
//     tap_en_o     out  1      taps updated this cycle (filter EN)
//     win_valid_o  out  1      taps complete a 3x3 window (r>=2 && c>=2)
//     win_col_o    out  CW     window top-left column (c-2)
//     win_row_o    out  RW     window top-left row (r-2)
//     eof_o        out  1      taps belong to the last pixel of the frame
//
//   Handshake: a beat transfers on a rising edge where pix_valid && pix_ready.
//   pix_ready depends only on hold_i; pix_valid may not depend on pix_ready.
module conv_line_buffer
    import conv_line_buffer_pkg::*;
#(
    parameter int IMG_W = CONV_IMG_W,
    parameter int IMG_H = CONV_IMG_H,
    // Must match CONV_PIX_W: the tap register uses the shared conv_tap_t.
    parameter int PIX_W = CONV_PIX_W,
    localparam int CW   = $clog2(IMG_W),
    localparam int RW   = $clog2(IMG_H)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             sof_i,
    input  logic             hold_i,
    output logic [PIX_W-1:0] tap0_o,
    output logic [PIX_W-1:0] tap1_o,
    output logic [PIX_W-1:0] tap2_o,
    output logic             tap_en_o,
    output logic             win_valid_o,
    output logic [CW-1:0]    win_col_o,
    output logic [RW-1:0]    win_row_o,
    output logic             eof_o
);

    logic             accept;
    logic [CW-1:0]    col_q, col_d, c_cur;
    logic [RW-1:0]    row_q, row_d, r_cur;
    logic [PIX_W-1:0] lb0_rdata, lb1_rdata;

    conv_tap_t        tap_q, tap_d;
    logic             tap_en_q, tap_en_d;
    logic             eof_q, eof_d;
    logic [CW-1:0]    win_col_q, win_col_d;
    logic [RW-1:0]    win_row_q, win_row_d;

    assign pix_ready = ~hold_i;
    assign accept    = pix_valid & pix_ready;

    // An accepted sof beat is pixel (0,0) wherever the counters are; this is
    // also the address used for both line buffers so a restarted frame
    // writes its first row from column 0.
    assign c_cur = sof_i ? '0 : col_q;
    assign r_cur = sof_i ? '0 : row_q;

    // lb1 holds row r-1, lb0 holds row r-2. On accept the column shifts up:
    // lb0[c] takes the old lb1[c], lb1[c] takes the new pixel.
    conv_lb_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb0 (
        .CLK     (CLK),
        .we_i    (accept),
        .waddr_i (c_cur),
        .wdata_i (lb1_rdata),
        .raddr_i (c_cur),
        .rdata_o (lb0_rdata)
    );

    conv_lb_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
        .CLK     (CLK),
        .we_i    (accept),
        .waddr_i (c_cur),
        .wdata_i (pix_i),
        .raddr_i (c_cur),
        .rdata_o (lb1_rdata)
    );

    always_comb begin
        col_d           = col_q;
        row_d           = row_q;
        tap_d           = tap_q;
        tap_d.win_valid = 1'b0;
        tap_en_d        = 1'b0;
        eof_d           = 1'b0;
        win_col_d       = win_col_q;
        win_row_d       = win_row_q;

        if (accept) begin
            tap_en_d   = 1'b1;
            tap_d.tap2 = pix_i;
            // Rows not yet written in this frame read as 0, which hides
            // stale RAM contents after reset or a mid-frame restart.
            tap_d.tap1 = (r_cur >= RW'(1)) ? lb1_rdata : '0;
            tap_d.tap0 = (r_cur >= RW'(2)) ? lb0_rdata : '0;

            tap_d.win_valid = (r_cur >= RW'(2)) && (c_cur >= CW'(2));
            // Subtract only where the result is meaningful so it never wraps.
            win_col_d = (c_cur >= CW'(2)) ? c_cur - CW'(2) : '0;
            win_row_d = (r_cur >= RW'(2)) ? r_cur - RW'(2) : '0;
            eof_d     = (r_cur == RW'(IMG_H - 1)) && (c_cur == CW'(IMG_W - 1));

            if (c_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (r_cur == RW'(IMG_H - 1)) ? '0 : r_cur + RW'(1);
            end else begin
                col_d = c_cur + CW'(1);
                row_d = r_cur;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            col_q     <= '0;
            row_q     <= '0;
            tap_q     <= '0;
            tap_en_q  <= 1'b0;
            eof_q     <= 1'b0;
            win_col_q <= '0;
            win_row_q <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            tap_q     <= tap_d;
            tap_en_q  <= tap_en_d;
            eof_q     <= eof_d;
            win_col_q <= win_col_d;
            win_row_q <= win_row_d;
        end
    end

    assign tap0_o      = tap_q.tap0;
    assign tap1_o      = tap_q.tap1;
    assign tap2_o      = tap_q.tap2;
    assign win_valid_o = tap_q.win_valid;
    assign tap_en_o    = tap_en_q;
    assign eof_o       = eof_q;
    assign win_col_o   = win_col_q;
    assign win_row_o   = win_row_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// tb_conv_line_buffer
//   Drives raster frames into conv_line_buffer and checks every tap set
//   against a frame-image reference model through an expected queue.
module tb_conv_line_buffer;

    localparam int IMG_W = 6;
    localparam int IMG_H = 6;
    localparam int PIX_W = 4;
    localparam int CW    = 3;
    localparam int RW    = 3;
    localparam int EXP_W = 3 * PIX_W + 1 + CW + RW + 1;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_i = '0;
    logic             sof_i = 1'b0;
    logic             hold_i = 1'b0;
    logic [PIX_W-1:0] tap0_o, tap1_o, tap2_o;
    logic             tap_en_o, win_valid_o, eof_o;
    logic [CW-1:0]    win_col_o;
    logic [RW-1:0]    win_row_o;

    conv_line_buffer dut (
        .CLK         (CLK),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_i       (pix_i),
        .sof_i       (sof_i),
        .hold_i      (hold_i),
        .tap0_o      (tap0_o),
        .tap1_o      (tap1_o),
        .tap2_o      (tap2_o),
        .tap_en_o    (tap_en_o),
        .win_valid_o (win_valid_o),
        .win_col_o   (win_col_o),
        .win_row_o   (win_row_o),
        .eof_o       (eof_o)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int tap_cnt  = 0;
    int win_cnt  = 0;
    int first_win = 0;

    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The frame as an image: a tap set at (r,c) is the column of pixels
    // directly above (r,c) in the frame currently being received.
    int m_row = 0;
    int m_col = 0;
    int img [IMG_H][IMG_W];
    int last_t0, last_t1, last_t2;

    task automatic model_accept(input int pix, input bit sof);
        int r, c, t0, t1, t2;
        bit wv, eof;
        r  = sof ? 0 : m_row;
        c  = sof ? 0 : m_col;
        t2 = pix;
        t1 = (r >= 1) ? img[r-1][c] : 0;
        t0 = (r >= 2) ? img[r-2][c] : 0;
        img[r][c] = pix;
        wv  = (r >= 2) && (c >= 2);
        eof = (r == IMG_H - 1) && (c == IMG_W - 1);
        exp_q.push_back({t0[PIX_W-1:0], t1[PIX_W-1:0], t2[PIX_W-1:0], wv,
                         wv ? 3'(c - 2) : 3'(0), wv ? 3'(r - 2) : 3'(0), eof});
        last_t0 = t0;
        last_t1 = t1;
        last_t2 = t2;
        c++;
        if (c == IMG_W) begin
            c = 0;
            r = (r == IMG_H - 1) ? 0 : r + 1;
        end
        m_row = r;
        m_col = c;
    endtask

    // ---------------- driver ----------------
    // Entered and left at #1 after a rising edge. Idle cycles carry junk
    // pixels and random sof to show nothing happens without accept.
    task automatic drive_beat(input int pix, input bit sof, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        pix_valid = 1'b0;
        repeat (gap) begin
            pix_i = PIX_W'($urandom);
            sof_i = 1'($urandom_range(1, 0));
            @(posedge CLK);
            #1;
        end
        pix_valid = 1'b1;
        pix_i     = PIX_W'(pix);
        sof_i     = sof;
        hold_i    = 1'b0;
        model_accept(pix, sof);
        @(posedge CLK);
        #1;
        pix_valid = 1'b0;
        sof_i     = 1'b0;
        pix_i     = PIX_W'($urandom);
    endtask

    // Let the monitor consume the last tap set before counting.
    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_counts();
        tap_cnt   = 0;
        win_cnt   = 0;
        first_win = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        logic [EXP_W-1:0] e;
        if (reset && tap_en_o) begin
            tap_cnt++;
            if (win_valid_o) begin
                win_cnt++;
                if (first_win == 0) first_win = tap_cnt;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_tap_en", 32'(tap_en_o), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("tap0", 32'(tap0_o), 32'(e[19:16]));
                check("tap1", 32'(tap1_o), 32'(e[15:12]));
                check("tap2", 32'(tap2_o), 32'(e[11:8]));
                check("win_valid", 32'(win_valid_o), 32'(e[7]));
                check("eof", 32'(eof_o), 32'(e[0]));
                if (e[7]) begin
                    check("win_col", 32'(win_col_o), 32'(e[6:4]));
                    check("win_row", 32'(win_row_o), 32'(e[3:1]));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tap0"}, 32'(tap0_o), 0);
        check({tag, "_tap1"}, 32'(tap1_o), 0);
        check({tag, "_tap2"}, 32'(tap2_o), 0);
        check({tag, "_tap_en"}, 32'(tap_en_o), 0);
        check({tag, "_win_valid"}, 32'(win_valid_o), 0);
        check({tag, "_win_col"}, 32'(win_col_o), 0);
        check({tag, "_win_row"}, 32'(win_row_o), 0);
        check({tag, "_eof"}, 32'(eof_o), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        check("ready_idle", 32'(pix_ready), 1);
        hold_i = 1'b1;
        #1;
        check("ready_hold", 32'(pix_ready), 0);
        hold_i = 1'b0;
        reset = 1'b1;
        @(posedge CLK);
        #1;

        // Frame A: ramp, no gaps, masking and fixed-window checks
        clear_counts();
        for (int k = 0; k < 36; k++) begin
            drive_beat((k + 1) % 16, k == 0, 0);
            if (k < 12) check("mask_tap0", 32'(tap0_o), 0);
            if (k < 6)  check("mask_tap1", 32'(tap1_o), 0);
            if (k < 14) check("mask_win", 32'(win_valid_o), 0);
            if (k == 14) begin
                check("k14_tap0", 32'(tap0_o), 3);
                check("k14_tap1", 32'(tap1_o), 9);
                check("k14_tap2", 32'(tap2_o), 15);
                check("k14_win_valid", 32'(win_valid_o), 1);
                check("k14_win_col", 32'(win_col_o), 0);
                check("k14_win_row", 32'(win_row_o), 0);
            end
            if (k == 35) begin
                // (5,5): above it are k=29 -> 30%16=14 and k=23 -> 24%16=8
                check("k35_eof", 32'(eof_o), 1);
                check("k35_tap0", 32'(tap0_o), 8);
                check("k35_tap1", 32'(tap1_o), 14);
                check("k35_tap2", 32'(tap2_o), 4);
            end
        end
        settle();
        check("frameA_tap_cnt", 32'(tap_cnt), 36);
        check("frameA_win_cnt", 32'(win_cnt), 16);
        check("frameA_first_win", 32'(first_win), 15);

        // Frame B: ramp with random gaps, stall at k=20
        for (int k = 0; k < 20; k++) drive_beat((k + 1) % 16, k == 0, 2);
        pix_valid = 1'b1;
        pix_i     = PIX_W'(21 % 16);
        hold_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(pix_ready), 0);
            @(posedge CLK);
            #1;
            check("stall_tap_en", 32'(tap_en_o), 0);
            check("stall_tap0", 32'(tap0_o), 32'(last_t0));
            check("stall_tap1", 32'(tap1_o), 32'(last_t1));
            check("stall_tap2", 32'(tap2_o), 32'(last_t2));
        end
        hold_i = 1'b0;
        drive_beat(21 % 16, 1'b0, 0);
        check("after_stall_tap2", 32'(tap2_o), 5);

        // Mid-frame sof at k=21 (r=3,c=3), then a frame of all 7s
        settle();
        clear_counts();
        drive_beat(7, 1'b1, 0);
        check("midsof_tap0", 32'(tap0_o), 0);
        check("midsof_tap1", 32'(tap1_o), 0);
        for (int k = 1; k < 36; k++) drive_beat(7, 1'b0, 2);
        settle();
        check("frame7_tap_cnt", 32'(tap_cnt), 36);
        check("frame7_win_cnt", 32'(win_cnt), 16);
        check("frame7_first_win", 32'(first_win), 15);

        // Frame D: ramp with sof at the expected (0,0), reset pulse at k=17
        @(posedge CLK);
        #1;
        for (int k = 0; k < 17; k++) drive_beat((k + 1) % 16, k == 0, 1);
        settle();
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        #1;
        reset = 1'b1;
        @(posedge CLK);
        #1;

        // Frame E: random pixels, no sof, random gaps
        clear_counts();
        for (int k = 0; k < 36; k++) begin
            drive_beat(int'($urandom_range(15, 0)), 1'b0, 2);
            if (k == 0) begin
                check("post_reset_tap0", 32'(tap0_o), 0);
                check("post_reset_tap1", 32'(tap1_o), 0);
            end
            if (k == 35) check("frameE_eof", 32'(eof_o), 1);
        end
        settle();
        check("frameE_tap_cnt", 32'(tap_cnt), 36);
        check("frameE_win_cnt", 32'(win_cnt), 16);
        check("queue_empty", 32'(exp_q.size()), 0);

        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
